// File: rtl/test_ram_sized_if.sv
// rtl/test_ram_sized_if.sv - request/response channel bundle for the sized test RAM
// The master side is the CPU bus model and the slave side is the RAM.
interface test_ram_sized_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [47:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [47:0] rsp_data;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_data
  );
endinterface

// File: rtl/test_ram_sized.sv
// rtl/test_ram_sized.sv - big-endian byte RAM with sized accesses and wait states
// One operation in flight; the commit edge either writes the store bytes or samples the load.
module test_ram_sized #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 48,
  parameter int WAIT_STATES = 0
) (
  input logic             clk,
  input logic             rst_n,
  test_ram_sized_if.slave bus
);

  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int LAST_CNT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              size_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_write_q;

  logic                    accept;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [1:0]              c_size;
  logic                    c_write;
  logic [DATA_WIDTH-1:0]   c_data;
  logic [DATA_WIDTH-1:0]   rd_al;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   wr_al;
  logic                    unused_addr_hi;

  logic [7:0] mem [2**ADDR_WIDTH];

  function automatic logic [5:0] field_shift(input logic [1:0] sz);
    case (sz)
      2'd0:    field_shift = 6'd40;
      2'd1:    field_shift = 6'd32;
      2'd2:    field_shift = 6'd16;
      default: field_shift = 6'd0;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      2'd2:    size_bytes = 3'd4;
      default: size_bytes = 3'd6;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(LAST_CNT)) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, so use the live bus.
  always_comb begin
    c_addr  = (state_q == S_IDLE) ? bus.req_addr[ADDR_WIDTH-1:0] : addr_q;
    c_size  = (state_q == S_IDLE) ? bus.req_size  : size_q;
    c_write = (state_q == S_IDLE) ? bus.req_write : write_q;
    c_data  = (state_q == S_IDLE) ? bus.req_data  : data_q;
    rd_al   = '0;
    for (int i = 0; i < NBYTES; i++) begin
      rd_al[8*(NBYTES-1-i) +: 8] = mem[c_addr + ADDR_WIDTH'(i)];
    end
    rd_data = rd_al >> field_shift(c_size);
    wr_al   = c_data << field_shift(c_size);
  end

  always_ff @(posedge clk) begin
    if (commit && c_write && rst_n) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (i < int'(size_bytes(c_size))) begin
          mem[c_addr + ADDR_WIDTH'(i)] <= wr_al[8*(NBYTES-1-i) +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.req_addr[ADDR_WIDTH-1:0];
        size_q  <= bus.req_size;
        write_q <= bus.req_write;
        data_q  <= bus.req_data;
      end
      if (commit) begin
        rsp_write_q <= c_write;
        rsp_data_q  <= c_write ? '0 : rd_data;
      end
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_data    = rsp_data_q;
  assign unused_addr_hi  = ^bus.req_addr[31:ADDR_WIDTH];

endmodule

// File: tb/tb_test_ram_sized.sv
// tb/tb_test_ram_sized.sv - scoreboard bench for the sized test RAM
// Two instances: zero wait states and three wait states, selected by sel.
module tb_test_ram_sized;

  typedef struct {
    logic        w;
    logic [47:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   sel;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic        m_req_valid, m_req_write, m_rsp_ready;
  logic [1:0]  m_req_size;
  logic [31:0] m_req_addr;
  logic [47:0] m_req_data;

  test_ram_sized_if bus0 ();
  test_ram_sized_if bus3 ();

  assign bus0.req_valid = sel ? 1'b0 : m_req_valid;
  assign bus0.req_write = m_req_write;
  assign bus0.req_size  = m_req_size;
  assign bus0.req_addr  = m_req_addr;
  assign bus0.req_data  = m_req_data;
  assign bus0.rsp_ready = sel ? 1'b0 : m_rsp_ready;
  assign bus3.req_valid = sel ? m_req_valid : 1'b0;
  assign bus3.req_write = m_req_write;
  assign bus3.req_size  = m_req_size;
  assign bus3.req_addr  = m_req_addr;
  assign bus3.req_data  = m_req_data;
  assign bus3.rsp_ready = sel ? m_rsp_ready : 1'b0;

  wire        s_req_ready = sel ? bus3.req_ready : bus0.req_ready;
  wire        s_rsp_valid = sel ? bus3.rsp_valid : bus0.rsp_valid;
  wire        s_rsp_write = sel ? bus3.rsp_write : bus0.rsp_write;
  wire [47:0] s_rsp_data  = sel ? bus3.rsp_data  : bus0.rsp_data;

  test_ram_sized #(.ADDR_WIDTH(16), .DATA_WIDTH(48), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  test_ram_sized #(.ADDR_WIDTH(16), .DATA_WIDTH(48), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The request lines are scrambled after accept to show the RAM uses the latched copy.
  task automatic do_op(input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [47:0] d, input logic [47:0] exp_d, input int hold);
    exp_t e;
    int   cyc;
    int   ws;
    ws  = sel ? 3 : 0;
    e.w = w;
    e.d = w ? 48'h0 : exp_d;
    sb.push_back(e);
    m_req_valid = 1'b1;
    m_req_write = w;
    m_req_size  = sz;
    m_req_addr  = a;
    m_req_data  = d;
    chk("req_ready_idle", 64'(s_req_ready), 64'd1);
    step();
    cyc = 1;
    m_req_addr  = $urandom;
    m_req_data  = {16'($urandom), 32'($urandom)};
    m_req_size  = 2'($urandom);
    m_req_write = ~w;
    while (!s_rsp_valid && cyc < 40) begin
      chk("req_ready_busy", 64'(s_req_ready), 64'd0);
      step();
      cyc++;
    end
    m_req_valid = 1'b0;
    chk("latency", 64'(cyc), 64'(ws + 1));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(s_rsp_valid), 64'd1);
      chk("hold_data", 64'(s_rsp_data), 64'(sb[0].d));
      chk("hold_req_ready", 64'(s_req_ready), 64'd0);
      step();
    end
    e = sb.pop_front();
    chk("rsp_valid", 64'(s_rsp_valid), 64'd1);
    chk("rsp_write", 64'(s_rsp_write), 64'(e.w));
    chk("rsp_data", 64'(s_rsp_data), 64'(e.d));
    m_rsp_ready = 1'b1;
    step();
    m_rsp_ready = 1'b0;
    chk("rsp_drop", 64'(s_rsp_valid), 64'd0);
    chk("idle_again", 64'(s_req_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 1'b0;
    m_req_valid = 1'b0;
    m_req_write = 1'b0;
    m_req_size = 2'd0;
    m_req_addr = '0;
    m_req_data = '0;
    m_rsp_ready = 1'b0;
    step();
    step();
    chk("rst0_req_ready", 64'(bus0.req_ready), 64'd1);
    chk("rst0_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    chk("rst0_rsp_write", 64'(bus0.rsp_write), 64'd0);
    chk("rst0_rsp_data", 64'(bus0.rsp_data), 64'd0);
    chk("rst3_req_ready", 64'(bus3.req_ready), 64'd1);
    chk("rst3_rsp_valid", 64'(bus3.rsp_valid), 64'd0);
    rst_n = 1'b1;
    step();

    do_op(1'b1, 2'd2, 32'h0010, 48'h0000_DEAD_BEEF, 48'h0, 0);
    do_op(1'b0, 2'd0, 32'h0011, 48'h0, 48'h0000_0000_00AD, 0);
    do_op(1'b0, 2'd1, 32'h0012, 48'h0, 48'h0000_0000_BEEF, 0);

    do_op(1'b1, 2'd3, 32'h0000_FFFE, 48'h1122_3344_5566, 48'h0, 0);
    do_op(1'b0, 2'd3, 32'h0000_FFFE, 48'h0, 48'h1122_3344_5566, 0);
    do_op(1'b0, 2'd1, 32'h0000_0000, 48'h0, 48'h0000_0000_3344, 0);
    do_op(1'b0, 2'd2, 32'hABCD_FFFF, 48'h0, 48'h0000_2233_4455, 0);

    do_op(1'b1, 2'd3, 32'h0020, 48'hFFFF_FFFF_FFFF, 48'h0, 0);
    do_op(1'b1, 2'd1, 32'h0021, 48'h0000_0000_ABCD, 48'h0, 0);
    do_op(1'b0, 2'd3, 32'h0020, 48'h0, 48'hFFAB_CDFF_FFFF, 0);

    sel = 1'b1;
    do_op(1'b1, 2'd2, 32'h0100, 48'h0000_CAFE_F00D, 48'h0, 5);
    do_op(1'b0, 2'd2, 32'h0100, 48'h0, 48'h0000_CAFE_F00D, 5);
    do_op(1'b1, 2'd1, 32'h0200, 48'h0000_0000_1234, 48'h0, 0);
    do_op(1'b0, 2'd1, 32'h0200, 48'h0, 48'h0000_0000_1234, 0);
    do_op(1'b0, 2'd0, 32'h0201, 48'h0, 48'h0000_0000_0034, 2);

    do_op(1'b1, 2'd0, 32'h0040, 48'h0000_0000_005A, 48'h0, 0);
    do_op(1'b0, 2'd0, 32'h0040, 48'h0, 48'h0000_0000_005A, 0);
    m_req_valid = 1'b1;
    m_req_write = 1'b1;
    m_req_size  = 2'd0;
    m_req_addr  = 32'h0040;
    m_req_data  = 48'h0000_0000_0077;
    step();
    m_req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(s_req_ready), 64'd1);
    chk("midrst_rsp_valid", 64'(s_rsp_valid), 64'd0);
    chk("midrst_rsp_write", 64'(s_rsp_write), 64'd0);
    chk("midrst_rsp_data", 64'(s_rsp_data), 64'd0);
    step();
    step();
    step();
    rst_n = 1'b1;
    step();
    do_op(1'b0, 2'd0, 32'h0040, 48'h0, 48'h0000_0000_005A, 0);

    sel = 1'b0;
    do_op(1'b0, 2'd0, 32'h0025, 48'h0, 48'h0000_0000_00FF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
